instruction_fetch: RTL
======================

# instruction_fetch

Instruction-fetch (IF) stage and IF/ID pipeline register for the MIPS pipeline. It generates the program counter, fetches words over a request/ready instruction-memory handshake, and presents `instruction32` to the decode stage. It also handles decode back-pressure (`stall`) and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC loaded on reset.
- `NOP_WORD`, default 32'h00000000: value driven on `instruction32` for a bubble.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetN` in 1: reset; one clock, reset is synchronous and active-low.
- `stall` in 1: decode cannot accept a new instruction this cycle.
- `redirect` in 1: branch or jump taken; fetch restarts at `redirectPc`.
- `redirectPc` in 32: redirect target; bits [1:0] are ignored and treated as 00.
- `imemReq` out 1: fetch request valid.
- `imemAddr` out 32: word-aligned fetch address; bits [1:0] are always 00.
- `imemReady` in 1: `imemData` is valid for the outstanding request this cycle.
- `imemData` in 32: fetched instruction word.
- `instruction32` out 32: IF/ID instruction register, feeds decode.
- `pcPlus4` out 32: IF/ID copy of the fetched PC + 4.
- `instrValid` out 1: IF/ID holds a real instruction, not a bubble.

## Operation
- Internal state: `pc`, `pendingPc`, `holdData`, `holdPc`, and a state register with states IDLE, FETCH, DISCARD, HOLD.
- Accept event: `imemReq && imemReady`. `imemReady` is ignored while `imemReq=0`.
- Handshake rule: once `imemReq` rises, `imemReq` and `imemAddr` stay stable until the accept event.
- IF/ID loads only when `!stall || !instrValid`, i.e. the register is empty or decode is consuming it.
  - If a load is allowed and no word is available: bubble. `instrValid` goes to 0 and `instruction32` to `NOP_WORD`; `pcPlus4` holds its value.
- `redirect` has priority over `stall` and over any data in flight.
  - A redirect always bubbles IF/ID that cycle.
- State transitions:
  - IDLE: `imemReq=0`. Always moves to FETCH on the next cycle.
  - FETCH: `imemReq=1`, `imemAddr=pc`.
    - Accept with `redirect`: drop the data, `pc<=redirectPc`, stay in FETCH.
    - Accept, no redirect, IF/ID can load: `instruction32<=imemData`, `pcPlus4<=pc+4`, `instrValid<=1`, `pc<=pc+4`, stay in FETCH.
    - Accept, no redirect, IF/ID stalled and valid: `holdData<=imemData`, `holdPc<=pc`, `pc<=pc+4`, go to HOLD.
    - No accept, `redirect`: `pendingPc<=redirectPc`, go to DISCARD. The address stays at the old `pc`.
  - DISCARD: `imemReq=1`, `imemAddr=pc` (the old address).
    - A further `redirect` overwrites `pendingPc`; the latest redirect wins.
    - On accept: drop the data, `pc<=pendingPc`, go to FETCH. If `redirect` is asserted in the same cycle, use `redirectPc` instead of `pendingPc`.
  - HOLD: `imemReq=0`.
    - `redirect`: drop `holdData`, `pc<=redirectPc`, go to FETCH.
    - Otherwise, when `stall=0`: load IF/ID from `holdData` with `pcPlus4<=holdPc+4`, go to FETCH.
- Arithmetic: all PC additions are 32-bit modulo 2^32, so 32'hFFFFFFFC + 4 = 32'h00000000. No flag is produced.
- Reset while `resetN=0`, regardless of state or any outstanding request:
  - `pc=RESET_PC`, state IDLE, `imemReq=0`, `imemAddr=RESET_PC`.
  - `instruction32=NOP_WORD`, `pcPlus4=RESET_PC`, `instrValid=0`.
  - Any in-flight response is abandoned. The memory must tolerate `imemReq` dropping at reset.

## Timing
- `imemReq` and `imemAddr` are decoded from registered state only; no combinational path from `imemReady` or `stall`.
- First request: the cycle after reset release is IDLE; `imemReq=1` in the following cycle.
- Zero-wait memory (`imemReady` in the same cycle as `imemReq`): throughput is 1 instruction per cycle. Each accepted word appears on `instruction32` one cycle after its accept edge.
- N-cycle memory: one request outstanding at a time, so throughput is 1 instruction per N cycles.
- Redirect penalty, zero-wait memory: the redirect cycle bubbles IF/ID and the target is requested the next cycle. Target valid in IF/ID 2 cycles after the redirect edge.
- Stall release from HOLD: `holdData` is valid in IF/ID on the first edge with `stall=0`. A new request issues in the following cycle.

## Test plan
- Reset and stream: release `resetN`, zero-wait memory returning `imemData=addr`.
  - Required: `imemAddr` sequence 0, 4, 8, 12.
  - Required: `instruction32` = 0, 4, 8 on consecutive cycles with `instrValid=1` and `pcPlus4` = 4, 8, 12.
- Stall with skid: stall=1 while IF/ID holds 0x04 and the word at 0x08 is accepted.
  - Required: state HOLD, `imemReq=0`, IF/ID still 0x04.
  - After stall=0 for one cycle: IF/ID=0x08, `pcPlus4`=0x0C, next `imemAddr`=0x0C.
- Redirect while idle-waiting: 3-cycle memory, `redirect=1`, `redirectPc`=0x100 at cycle 1 of the request to 0x08.
  - Required: `imemAddr` stays 0x08 until ready, the data is dropped, then `imemAddr`=0x100.
  - Required: `instrValid=0` until the word at 0x100 arrives.
- Double redirect in DISCARD: redirects to 0x100 then 0x200 before ready.
  - Required: only 0x200 is fetched; neither the 0x08 nor the 0x100 data reaches IF/ID.
- Redirect beats stall: `stall=1`, `redirect=1`, state HOLD.
  - Required: `instrValid=0`, `instruction32`=`NOP_WORD`, `holdData` discarded, `imemAddr`=target next cycle.
- Wrap and mid-request reset:
  - `redirectPc`=32'hFFFFFFFE fetches 0xFFFFFFFC, then `pcPlus4`=0x00000000 and the next address is 0x0.
  - Asserting `resetN=0` mid-request returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage with request/ready imem handshake and IF/ID register.
// A redirect during an outstanding request is deferred in DISCARD until the old response drains.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instruction32,
    output logic [31:0] pcPlus4,
    output logic        instrValid
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

    state_t      state;
    logic [31:0] pc, pendingPc, holdData, holdPc, target;
    logic        accept, can_load;

    assign target   = redirectPc & 32'hFFFF_FFFC;
    assign accept   = imemReq && imemReady;
    assign can_load = !stall || !instrValid;
    assign imemReq  = (state == FETCH) || (state == DISCARD);
    assign imemAddr = pc;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= IDLE;
            pc            <= RESET_PC & 32'hFFFF_FFFC;
            pendingPc     <= RESET_PC;
            holdData      <= NOP_WORD;
            holdPc        <= RESET_PC;
            instruction32 <= NOP_WORD;
            pcPlus4       <= RESET_PC;
            instrValid    <= 1'b0;
        end else begin
            // Bubble by default; the load cases below override it.
            if (redirect || can_load) begin
                instruction32 <= NOP_WORD;
                instrValid    <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (redirect) pc <= target;
                end
                FETCH: begin
                    if (redirect) begin
                        if (accept) pc <= target;
                        else begin
                            pendingPc <= target;
                            state     <= DISCARD;
                        end
                    end else if (accept) begin
                        pc <= pc + 32'd4;
                        if (can_load) begin
                            instruction32 <= imemData;
                            pcPlus4       <= pc + 32'd4;
                            instrValid    <= 1'b1;
                        end else begin
                            holdData <= imemData;
                            holdPc   <= pc;
                            state    <= HOLD;
                        end
                    end
                end
                DISCARD: begin
                    if (accept) begin
                        pc    <= redirect ? target : pendingPc;
                        state <= FETCH;
                    end else if (redirect) pendingPc <= target;
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= FETCH;
                    end else if (!stall) begin
                        instruction32 <= holdData;
                        pcPlus4       <= holdPc + 32'd4;
                        instrValid    <= 1'b1;
                        state         <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
